decode_stage_param: RTL and testbench

Parametrised RISC-V integer decode stage with an integrated register file, immediate generation, load-use hazard detection and valid/ready handshakes on both sides. It sits between fetch and execute and replaces the fixed 64-bit, always-advancing decoder. It adds XLEN/register-count generality and store, LUI/AUIPC and JAL/JALR decode. It also adds back-pressure, flush, and refresh of a held entry when writeback lands on it.

---
 rtl/decode_stage_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_decode_stage_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_param.sv
// RISC-V integer decode stage: register file, immediates, load-use stall, valid/ready.
// Optional DECODE_WB_BYPASS_EN: same-cycle writeback bypass on RF reads.
module decode_stage_param #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_o,
    output logic            write_back,
    output logic            imm_flag,
    output logic            mem_acc,
    output logic            load_flag,
    output logic            store_flag,
    output logic            branch_flag,
    output logic            jump_flag,
    output logic            word_inst,
    output logic            illegal,
    output logic            stall_raise
);
    localparam int RIDX = $clog2(NREG);
    localparam logic [5:0] NR = 6'(NREG);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RW    = 7'b0111011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_IW    = 7'b0011011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // s_* mark which operand slots came from rs1/rs2, for held-entry refresh
    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] sd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            wb;
        logic            immf;
        logic            mem;
        logic            ld;
        logic            st;
        logic            br;
        logic            jmp;
        logic            word;
        logic            ill;
        logic            s_op1;
        logic            s_op2;
        logic            s_sd;
    } ent_t;

    logic [XLEN-1:0] rf [NREG];
    ent_t d, q;
    logic ov, ill, u_rd, u1, u2, hazard, accept;
    logic [XLEN-1:0] v1, v2;

    logic [6:0] opc;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = inst[6:0];
    assign rd_f  = inst[11:7];
    assign rs1_f = inst[19:15];
    assign rs2_f = inst[24:20];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    always_comb begin
        v1 = '0;
        v2 = '0;
        if (rs1_f != 5'd0 && {1'b0, rs1_f} < NR) v1 = rf[rs1_f[RIDX-1:0]];
        if (rs2_f != 5'd0 && {1'b0, rs2_f} < NR) v2 = rf[rs2_f[RIDX-1:0]];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_rd != 5'd0 && wb_rd == rs1_f) v1 = wb_value;
        if (wb_en && wb_rd != 5'd0 && wb_rd == rs2_f) v2 = wb_value;
`endif
    end

    always_comb begin
        d    = '0;
        d.pc = pc_i;
        ill  = 1'b0;
        u_rd = 1'b0;
        u1   = 1'b0;
        u2   = 1'b0;
        unique case (opc)
            OP_R, OP_RW: begin
                {u_rd, u1, u2} = 3'b111;
                d.f3 = inst[14:12]; d.f7 = inst[31:25];
                d.op1 = v1; d.op2 = v2; d.wb = 1'b1;
                d.s_op1 = 1'b1; d.s_op2 = 1'b1;
                d.word = (opc == OP_RW);
            end
            OP_I, OP_IW: begin
                {u_rd, u1} = 2'b11;
                d.f3 = inst[14:12];
                d.op1 = v1; d.op2 = imm_i; d.imm = imm_i;
                d.immf = 1'b1; d.wb = 1'b1; d.s_op1 = 1'b1;
                d.word = (opc == OP_IW);
            end
            OP_LD: begin
                {u_rd, u1} = 2'b11;
                d.f3 = inst[14:12];
                d.op1 = v1; d.op2 = imm_i; d.imm = imm_i;
                d.mem = 1'b1; d.ld = 1'b1; d.wb = 1'b1; d.s_op1 = 1'b1;
            end
            OP_ST: begin
                {u1, u2} = 2'b11;
                d.f3 = inst[14:12];
                d.op1 = v1; d.op2 = imm_s; d.imm = imm_s; d.sd = v2;
                d.mem = 1'b1; d.st = 1'b1;
                d.s_op1 = 1'b1; d.s_sd = 1'b1;
            end
            OP_BR: begin
                {u1, u2} = 2'b11;
                d.f3 = inst[14:12];
                d.op1 = v1; d.op2 = v2; d.imm = imm_b; d.br = 1'b1;
                d.s_op1 = 1'b1; d.s_op2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                u_rd = 1'b1;
                d.op1 = (opc == OP_AUIPC) ? pc_i : '0;
                d.op2 = imm_u; d.imm = imm_u;
                d.immf = 1'b1; d.wb = 1'b1;
            end
            OP_JAL: begin
                u_rd = 1'b1;
                d.op1 = pc_i; d.op2 = XLEN'(4); d.imm = imm_j;
                d.immf = 1'b1; d.jmp = 1'b1; d.wb = 1'b1;
            end
            OP_JALR: begin
                {u_rd, u1} = 2'b11;
                d.f3 = inst[14:12];
                d.op1 = v1; d.op2 = XLEN'(4); d.imm = imm_i;
                d.jmp = 1'b1; d.wb = 1'b1; d.s_op1 = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (u_rd) d.rd = rd_f;
        if (u1) d.rs1 = rs1_f;
        if (u2) d.rs2 = rs2_f;
        if ((u_rd && {1'b0, rd_f} >= NR) || (u1 && {1'b0, rs1_f} >= NR) ||
            (u2 && {1'b0, rs2_f} >= NR) || (d.word && XLEN == 32))
            ill = 1'b1;
        if (ill) begin
            d     = '0;
            d.pc  = pc_i;
            d.ill = 1'b1;
        end
    end

    always_comb begin
        hazard = ov && q.ld && q.rd != 5'd0 &&
                 (rs1_f == q.rd || (u2 && rs2_f == q.rd));
`ifndef DECODE_WB_BYPASS_EN
        // no bypass: wait one cycle for the write to land in the RF
        if (wb_en && wb_rd != 5'd0 && (rs1_f == wb_rd || (u2 && rs2_f == wb_rd)))
            hazard = 1'b1;
`endif
    end

    assign in_ready    = !flush && !hazard && (!ov || out_ready);
    assign accept      = in_valid && in_ready;
    assign stall_raise = in_valid && hazard;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0 && {1'b0, wb_rd} < NR) begin
            rf[wb_rd[RIDX-1:0]] <= wb_value;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            ov <= 1'b0;
            q  <= '0;
        end else if (flush) begin
            ov <= 1'b0;
        end else if (accept) begin
            ov <= 1'b1;
            q  <= d;
        end else if (out_ready) begin
            ov <= 1'b0;
        end else if (ov && wb_en && wb_rd != 5'd0) begin
            if (q.s_op1 && q.rs1 == wb_rd) q.op1 <= wb_value;
            if (q.s_op2 && q.rs2 == wb_rd) q.op2 <= wb_value;
            if (q.s_sd && q.rs2 == wb_rd) q.sd <= wb_value;
        end
    end

    assign out_valid   = ov;
    assign rd          = q.rd;
    assign rs1         = q.rs1;
    assign rs2         = q.rs2;
    assign funct3      = q.f3;
    assign funct7      = q.f7;
    assign op1         = q.op1;
    assign op2         = q.op2;
    assign store_data  = q.sd;
    assign imm         = q.imm;
    assign pc_o        = q.pc;
    assign write_back  = q.wb;
    assign imm_flag    = q.immf;
    assign mem_acc     = q.mem;
    assign load_flag   = q.ld;
    assign store_flag  = q.st;
    assign branch_flag = q.br;
    assign jump_flag   = q.jmp;
    assign word_inst   = q.word;
    assign illegal     = q.ill;
endmodule

// File: tb/tb_decode_stage_param.sv
// Directed bench for decode_stage_param.
// Default 64/32 build plus a 32/16 build.
module tb_decode_stage_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  logic        in_valid, in_ready, flush, wb_en;
  logic        out_valid, out_ready;
  logic [31:0] inst;
  logic [63:0] pc_i, wb_value, op1, op2;
  logic [63:0] store_data, imm, pc_o;
  logic [4:0]  wb_rd, rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic write_back, imm_flag, mem_acc;
  logic load_flag, store_flag;
  logic branch_flag, jump_flag, word_inst;
  logic illegal, stall_raise;

  decode_stage_param dut (
    .CLK(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc_i(pc_i), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_value(wb_value), .out_valid(out_valid),
    .out_ready(out_ready), .rd(rd),
    .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7),
    .op1(op1), .op2(op2),
    .store_data(store_data), .imm(imm),
    .pc_o(pc_o),
    .write_back(write_back), .imm_flag(imm_flag),
    .mem_acc(mem_acc),
    .load_flag(load_flag), .store_flag(store_flag),
    .branch_flag(branch_flag),
    .jump_flag(jump_flag),
    .word_inst(word_inst), .illegal(illegal),
    .stall_raise(stall_raise)
  );

  logic        n_in_valid, n_in_ready, n_flush;
  logic        n_wb_en, n_out_valid, n_out_ready;
  logic [31:0] n_inst, n_pc_i, n_wb_value;
  logic [31:0] n_op1, n_op2, n_store_data;
  logic [31:0] n_imm, n_pc_o;
  logic [4:0]  n_wb_rd, n_rd, n_rs1, n_rs2;
  logic [2:0]  n_funct3;
  logic [6:0]  n_funct7;
  logic n_write_back, n_imm_flag, n_mem_acc;
  logic n_load_flag, n_store_flag;
  logic n_branch_flag, n_jump_flag, n_word_inst;
  logic n_illegal, n_stall_raise;

  decode_stage_param #(.XLEN(32), .NREG(16)) dut_n (
    .CLK(clk), .reset(reset),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .inst(n_inst), .pc_i(n_pc_i), .flush(n_flush),
    .wb_en(n_wb_en), .wb_rd(n_wb_rd),
    .wb_value(n_wb_value), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .rd(n_rd),
    .rs1(n_rs1), .rs2(n_rs2),
    .funct3(n_funct3), .funct7(n_funct7),
    .op1(n_op1), .op2(n_op2),
    .store_data(n_store_data), .imm(n_imm),
    .pc_o(n_pc_o),
    .write_back(n_write_back),
    .imm_flag(n_imm_flag),
    .mem_acc(n_mem_acc),
    .load_flag(n_load_flag),
    .store_flag(n_store_flag),
    .branch_flag(n_branch_flag),
    .jump_flag(n_jump_flag),
    .word_inst(n_word_inst), .illegal(n_illegal),
    .stall_raise(n_stall_raise)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; inst = '0;
    pc_i = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_value = '0;
    out_ready = 1'b1;
    n_in_valid = 1'b0; n_inst = '0; n_pc_i = '0;
    n_flush = 1'b0;
    n_wb_en = 1'b0; n_wb_rd = '0; n_wb_value = '0;
    n_out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_op1", op1, 64'h0);
    chk("rst_wb", write_back, 1'b0);
    chk("rst_n_out_valid", n_out_valid, 1'b0);
    reset = 1'b1;
    tick();

    inst = 32'h00500093; pc_i = 64'h100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_op1", op1, 64'h0);
    chk("addi_op2", op2, 64'h5);
    chk("addi_rd", rd, 5'd1);
    chk("addi_immf", imm_flag, 1'b1);
    chk("addi_wb", write_back, 1'b1);
    chk("addi_pc", pc_o, 64'h100);

    inst = 32'h0000B103; in_valid = 1'b1;
    #1 chk("ld_in_ready", in_ready, 1'b1);
    tick();
    inst = 32'h002101B3;
    #1;
    chk("ld_loadflag", load_flag, 1'b1);
    chk("ld_memacc", mem_acc, 1'b1);
    chk("lu_stall", stall_raise, 1'b1);
    chk("lu_in_ready", in_ready, 1'b0);
    tick();
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_stall", stall_raise, 1'b0);
    tick();
    chk("add_valid", out_valid, 1'b1);
    chk("add_rd", rd, 5'd3);
    chk("add_rs2", rs2, 5'd2);
    inst = 32'h00100213;
    #1 chk("addi4_nostall", stall_raise, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("addi4_rd", rd, 5'd4);
    chk("addi4_op2", op2, 64'h1);
    tick();

    inst = 32'h00028333; in_valid = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd5; wb_value = 64'hDEAD;
`ifdef DECODE_WB_BYPASS_EN
    #1 chk("byp_nostall", stall_raise, 1'b0);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
`else
    #1 chk("nobyp_stall", stall_raise, 1'b1);
    tick();
    wb_en = 1'b0;
    chk("nobyp_wait", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
`endif
    chk("byp_valid", out_valid, 1'b1);
    chk("byp_op1", op1, 64'hDEAD);
    chk("byp_rd", rd, 5'd6);

    inst = 32'h009403B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("held_rd", rd, 5'd7);
    chk("held_op2_pre", op2, 64'h0);
    wb_en = 1'b1; wb_rd = 5'd9; wb_value = 64'h77;
    tick();
    wb_en = 1'b0;
    chk("refresh_valid", out_valid, 1'b1);
    chk("refresh_op2", op2, 64'h77);
    chk("refresh_op1", op1, 64'h0);

    inst = 32'h00100213; in_valid = 1'b1;
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_rd_kept", rd, 5'd7);

    inst = 32'h00943423; pc_i = 64'h180;
    in_valid = 1'b1;
    tick();
    chk("sd_store", store_flag, 1'b1);
    chk("sd_wb", write_back, 1'b0);
    chk("sd_data", store_data, 64'h77);
    chk("sd_op2", op2, 64'h8);
    chk("sd_rd", rd, 5'd0);

    inst = 32'hFFDFF0EF; pc_i = 64'h200;
    tick();
    chk("jal_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_op1", op1, 64'h200);
    chk("jal_op2", op2, 64'h4);
    chk("jal_jump", jump_flag, 1'b1);
    chk("jal_immf", imm_flag, 1'b1);

    inst = 32'h0000007F;
    tick();
    in_valid = 1'b0;
    chk("ill_valid", out_valid, 1'b1);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_wb", write_back, 1'b0);

    n_inst = 32'h003100BB; n_in_valid = 1'b1;
    tick();
    chk("n_addw_ill", n_illegal, 1'b1);
    chk("n_addw_word", n_word_inst, 1'b0);
    n_inst = 32'h00100A13;
    tick();
    chk("n_x20_ill", n_illegal, 1'b1);
    chk("n_x20_wb", n_write_back, 1'b0);
    n_inst = 32'h800000B7;
    tick();
    n_in_valid = 1'b0;
    chk("n_lui_ill", n_illegal, 1'b0);
    chk("n_lui_op2", n_op2, 32'h8000_0000);
    chk("n_lui_op1", n_op1, 32'h0);
    chk("n_lui_wb", n_write_back, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
